// File: rtl/mem_block_copier.sv
// Forward DMA byte-range copier for the word-wide memory port.
// Full words copy with READ/WRITE; a sub-word tail is merged with the destination word.
module mem_block_copier #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [ADDR_WIDTH-1:0]  byte_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [BYTE_SIZE*8-1:0] mem_wd,
  input  logic [BYTE_SIZE*8-1:0] mem_rd
);

  localparam int DW = BYTE_SIZE * 8;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTE_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [DW-1:0]         data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= byte_count;
            busy      <= 1'b1;
            if (byte_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          data  <= mem_rd;
          state <= (remaining >= STEP) ? WRITE : MERGE;
        end
        MERGE: begin
          // Lanes past the tail keep the destination's existing bytes
          for (int i = 0; i < BYTE_SIZE; i++) begin
            if (ADDR_WIDTH'(i) >= remaining)
              data[8*i+:8] <= mem_rd[8*i+:8];
          end
          state <= WRITE;
        end
        WRITE: begin
          if (remaining <= STEP) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            src_ptr   <= src_ptr + STEP;
            dst_ptr   <= dst_ptr + STEP;
            remaining <= remaining - STEP;
            state     <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    case (state)
      READ:  mem_addr = src_ptr;
      MERGE: mem_addr = dst_ptr;
      WRITE: begin
        mem_addr = dst_ptr;
        mem_we   = 1'b1;
        mem_wd   = data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a 256-byte memory model.
// Each scenario task checks timing and memory contents inline.
module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [31:0] byte_count = '0;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [7:0] mem [0:255];
  logic       clr = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_a = '0;
  logic [7:0] poke_d = '0;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  mem_block_copier #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .byte_count(byte_count),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 4; i++)
      mem_rd[8*i+:8] = mem[8'(mem_addr[7:0] + 8'(i))];
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i < 16) ? 8'(i + 1) : 8'h00;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wd[8*i+:8];
    end
  end

  task automatic init_mem();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Caller is at a negedge; start is raised here, so back-to-back use is direct.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] n, input bit glitch,
                          output int cyc, output int wr,
                          output int dn, output int dcyc);
    cyc = 0; wr = 0; dn = 0; dcyc = -1;
    src_addr = s; dst_addr = d; byte_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 100) begin
      cyc++;
      if (mem_we) wr++;
      if (done) begin dn++; dcyc = cyc; end
      if (glitch && cyc == 1) begin
        start = 1'b1; src_addr = 32'h40;
        dst_addr = 32'h48; byte_count = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    nchecks++;
    if (cyc >= 100) begin
      nerrors++;
      $display("FAIL copy_timeout: busy still %0b after %0d cycles", busy, cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    chki("reset_busy", busy, 0);
    chki("reset_done", done, 0);
    chki("reset_we", mem_we, 0);
    chki("reset_addr", mem_addr, 0);
    chki("reset_wd", mem_wd, 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    int c, w, dn, dc;
    init_mem();
    run_copy(32'd0, 32'd16, 32'd8, 1'b0, c, w, dn, dc);
    chki("aligned_cycles", c, 5);
    chki("aligned_writes", w, 2);
    chki("aligned_done_count", dn, 1);
    chki("aligned_done_cycle", dc, 5);
    for (int i = 0; i < 8; i++)
      chk8($sformatf("aligned_mem%0d", 16 + i), mem[16 + i], 8'(i + 1));
    chk8("aligned_mem24", mem[24], 8'h00);
  endtask

  task automatic test_tail();
    int c, w, dn, dc;
    init_mem();
    poke(8'd0, 8'h11); poke(8'd1, 8'h22);
    poke(8'd2, 8'h33); poke(8'd3, 8'h44);
    for (int i = 32; i < 36; i++) poke(8'(i), 8'hAA);
    run_copy(32'd0, 32'd32, 32'd3, 1'b0, c, w, dn, dc);
    chki("tail_cycles", c, 4);
    chki("tail_writes", w, 1);
    chki("tail_done_cycle", dc, 4);
    chk8("tail_mem32", mem[32], 8'h11);
    chk8("tail_mem33", mem[33], 8'h22);
    chk8("tail_mem34", mem[34], 8'h33);
    chk8("tail_mem35", mem[35], 8'hAA);
  endtask

  task automatic test_zero();
    int c, w, dn, dc;
    init_mem();
    run_copy(32'd0, 32'd16, 32'd0, 1'b0, c, w, dn, dc);
    chki("zero_cycles", c, 1);
    chki("zero_writes", w, 0);
    chki("zero_done_cycle", dc, 1);
    chk8("zero_mem16", mem[16], 8'h00);
  endtask

  task automatic test_start_while_busy();
    int c, w, dn, dc;
    init_mem();
    run_copy(32'd0, 32'd80, 32'd8, 1'b1, c, w, dn, dc);
    chki("busy_start_cycles", c, 5);
    chki("busy_start_writes", w, 2);
    chki("busy_start_done", dn, 1);
    for (int i = 0; i < 8; i++)
      chk8($sformatf("busy_start_mem%0d", 80 + i), mem[80 + i], 8'(i + 1));
    chk8("busy_start_mem72", mem[72], 8'h00);
    chki("busy_start_idle", busy, 0);
  endtask

  task automatic test_back_to_back();
    int c, w, dn, dc;
    logic [7:0] exp_ov [0:10];
    exp_ov = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h04, 8'h05, 8'h0A, 8'h0B};
    init_mem();
    for (int i = 100; i < 104; i++) poke(8'(i), 8'hEE);
    run_copy(32'd1, 32'd3, 32'd6, 1'b0, c, w, dn, dc);
    chki("overlap_cycles", c, 6);
    chki("overlap_writes", w, 2);
    for (int i = 0; i < 11; i++)
      chk8($sformatf("overlap_mem%0d", i), mem[i], exp_ov[i]);
    run_copy(32'd0, 32'd96, 32'd5, 1'b0, c, w, dn, dc);
    chki("b2b_cycles", c, 6);
    chki("b2b_done_cycle", dc, 6);
    chk8("b2b_mem96", mem[96], 8'h01);
    chk8("b2b_mem99", mem[99], 8'h02);
    chk8("b2b_mem100", mem[100], 8'h03);
    chk8("b2b_mem101", mem[101], 8'hEE);
    chk8("b2b_mem103", mem[103], 8'hEE);
  endtask

  task automatic test_reset_mid_copy();
    int c, w, dn, dc, k;
    init_mem();
    src_addr = 32'd0; dst_addr = 32'd64;
    byte_count = 32'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!mem_we && k < 20) begin
      k++;
      @(negedge clk);
    end
    chki("mid_reach_write", mem_we, 1);
    reset = 1'b1;
    #1;
    chki("mid_we", mem_we, 0);
    chki("mid_addr", mem_addr, 0);
    chki("mid_wd", mem_wd, 0);
    chki("mid_busy", busy, 0);
    chki("mid_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_we || busy) w++;
      @(negedge clk);
    end
    chki("mid_no_activity", w, 0);
    chk8("mid_mem64", mem[64], 8'h00);
    run_copy(32'd0, 32'd64, 32'd4, 1'b0, c, w, dn, dc);
    chki("mid_restart_cycles", c, 3);
    chk8("mid_restart_mem64", mem[64], 8'h01);
    chk8("mid_restart_mem67", mem[67], 8'h04);
    chk8("mid_restart_mem68", mem[68], 8'h00);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_tail();
    test_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
